// File: rtl/twos_comp_serial_decoder.sv
// -----------------------------------------------------------------------------
// twos_comp_serial_decoder
//
// Receiving end of the serial two's-complement link. Each framed, LSB-first
// serial word carries -X. The decoder negates it bit-serially as it arrives
// (copy bits up to and including the first 1, invert every bit after that),
// deserializes the result into a W-bit word, and hands it downstream over a
// valid/ready handshake.
//
// Ports
//   clk        in   1  clock, rising edge
//   n_reset    in   1  asynchronous active-low reset
//   in_valid   in   1  serial bit present on in_bit
//   in_bit     in   1  serial data bit, LSB first
//   in_first   in   1  in_bit is bit 0 of a new word
//   in_ready   out  1  decoder accepts the bit this cycle
//   out_valid  out  1  out_data holds a completed word
//   out_ready  in   1  downstream accepts the word
//   out_data   out  W  recovered value X = (-R) mod 2^W
//   out_neg    out  1  out_data[W-1]
//   out_ovf    out  1  R was 100..0 (negation overflowed)
//   frame_err  out  1  sticky framing error, cleared only by reset
// -----------------------------------------------------------------------------
module twos_comp_serial_decoder #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         in_valid,
    input  logic         in_bit,
    input  logic         in_first,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_neg,
    output logic         out_ovf,
    output logic         frame_err
);

    localparam int unsigned CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COPY,
        S_INVERT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [W-1:0]    r_shift;
    logic            r_out_valid;
    logic [W-1:0]    r_out_data;
    logic            r_out_neg;
    logic            r_out_ovf;
    logic            r_frame_err;

    logic            w_accept;
    logic            w_d;
    logic            w_complete;
    logic            w_ferr;
    logic            w_shift_bit;
    logic [W-1:0]    w_word;

    // Stall only when the final bit would overwrite a word nobody has taken.
    assign in_ready  = ~(r_out_valid & ~out_ready & (r_cnt == LAST));

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_neg   = r_out_neg;
    assign out_ovf   = r_out_ovf;
    assign frame_err = r_frame_err;

    // Decoded bit: a word's first bit is always copied; after the first 1
    // every further bit is inverted.
    assign w_d    = (in_first || (r_state != S_INVERT)) ? in_bit : ~in_bit;
    assign w_word = {w_d, r_shift[W-2:0]};

    always_comb begin
        w_accept    = in_valid & in_ready;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_complete  = 1'b0;
        w_ferr      = 1'b0;
        w_shift_bit = 1'b0;
        if (w_accept) begin
            if (in_first) begin
                // A new frame start always wins; any partial word is dropped.
                w_cnt_nxt   = CW'(1);
                w_state_nxt = in_bit ? S_INVERT : S_COPY;
                w_ferr      = (r_state != S_IDLE);
            end else if (r_state == S_IDLE) begin
                w_ferr = 1'b1;
            end else if (r_cnt == LAST) begin
                w_complete  = 1'b1;
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_shift_bit = 1'b1;
                w_cnt_nxt   = r_cnt + CW'(1);
                if ((r_state == S_COPY) && in_bit) begin
                    w_state_nxt = S_INVERT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_shift <= '0;
        end else if (w_accept && in_first) begin
            r_shift    <= '0;
            r_shift[0] <= in_bit;
        end else if (w_shift_bit) begin
            r_shift[r_cnt] <= w_d;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_neg   <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else if (w_complete) begin
            // A completing word may replace one being taken this same cycle.
            r_out_valid <= 1'b1;
            r_out_data  <= w_word;
            r_out_neg   <= w_d;
            r_out_ovf   <= (r_state == S_COPY) & in_bit;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_frame_err <= 1'b0;
        end else if (w_ferr) begin
            r_frame_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_twos_comp_serial_decoder.sv
// -----------------------------------------------------------------------------
// tb_twos_comp_serial_decoder
//
// Bench for twos_comp_serial_decoder (W = 8): directed cases for the main
// negation rules, back-pressure, framing errors and reset, followed by 1000
// random words with random input gaps and random out_ready. Expected words
// come from plain modulo arithmetic on the transmitted value R.
// -----------------------------------------------------------------------------
module tb_twos_comp_serial_decoder;

    localparam int unsigned W = 8;
    localparam int unsigned NWORDS = 1000;

    logic         clk;
    logic         n_reset;
    logic         in_valid;
    logic         in_bit;
    logic         in_first;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_neg;
    logic         out_ovf;
    logic         frame_err;

    int unsigned  n_total;
    int unsigned  n_pass;
    int unsigned  n_rx;
    logic         mon_en;
    logic         rand_rdy;
    logic [W-1:0] exp_q[$];

    twos_comp_serial_decoder #(.W(W)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_first  (in_first),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_neg   (out_neg),
        .out_ovf   (out_ovf),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: recovered value is the modulo-2^W negation of R.
    function automatic logic [W-1:0] neg_of(input logic [W-1:0] r);
        int unsigned v;
        v = ((1 << W) - int'(r)) % (1 << W);
        return W'(v);
    endfunction

    // Directed sender: bits lo..hi-1 of r, one per cycle, in_first on bit 0.
    task automatic send_range(input logic [W-1:0] r, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            in_valid = 1'b1;
            in_bit   = r[i];
            in_first = (i == 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Handshaked sender with a bounded wait on in_ready.
    task automatic send_bit_hs(input logic b, input logic f);
        logic rdy;
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_bit   = b;
        in_first = f;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            rdy = in_ready;
            idle_cycle();
            done = rdy;
        end
        in_valid = 1'b0;
        in_first = 1'b0;
        if (!done) chk("accept_timeout", 32'(done), 32'd1);
    endtask

    task automatic word_check(input logic [W-1:0] r, input string tag,
                              input logic [W-1:0] x, input logic n, input logic o);
        send_range(r, 0, W);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data), 32'(x));
        chk({tag, "_neg"},   32'(out_neg), 32'(n));
        chk({tag, "_ovf"},   32'(out_ovf), 32'(o));
    endtask

    // Scoreboard: every handshaken word must match the oldest sent word.
    always @(negedge clk) begin
        if (mon_en && n_reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [W-1:0] r;
                logic [W-1:0] x;
                r = exp_q.pop_front();
                x = neg_of(r);
                chk("rnd_data", 32'(out_data), 32'(x));
                chk("rnd_neg",  32'(out_neg), 32'(x[W-1]));
                chk("rnd_ovf",  32'(out_ovf), 32'(r == 8'h80));
                n_rx++;
            end
        end
    end

    initial begin
        n_total   = 0;
        n_pass    = 0;
        n_rx      = 0;
        mon_en    = 1'b0;
        rand_rdy  = 1'b0;
        n_reset   = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        in_first  = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data), 32'd0);
        chk("rst_neg",   32'(out_neg), 32'd0);
        chk("rst_ovf",   32'(out_ovf), 32'd0);
        chk("rst_ferr",  32'(frame_err), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 n_reset = 1'b1;

        // R = 0x03: valid appears one cycle after the MSB, for one cycle only
        send_range(8'h03, 0, W - 1);
        in_valid = 1'b1;
        in_bit   = 1'b0;
        @(negedge clk);
        chk("w03_valid_pre", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("w03_valid", 32'(out_valid), 32'd1);
        chk("w03_data",  32'(out_data), 32'hFD);
        chk("w03_neg",   32'(out_neg), 32'd1);
        chk("w03_ovf",   32'(out_ovf), 32'd0);
        @(negedge clk);
        chk("w03_valid_post", 32'(out_valid), 32'd0);

        // Width boundaries
        word_check(8'h80, "w80", 8'h80, 1'b1, 1'b1);
        word_check(8'h00, "w00", 8'h00, 1'b0, 1'b0);
        word_check(8'hFF, "wFF", 8'h01, 1'b0, 1'b0);
        @(negedge clk);

        // Back-pressure: second word's MSB stalls until the first is taken
        out_ready = 1'b0;
        send_range(8'h05, 0, W);
        send_range(8'h10, 0, W - 1);
        in_valid = 1'b1;
        in_bit   = 1'b0;
        @(negedge clk);
        chk("bp_ready0", 32'(in_ready), 32'd0);
        chk("bp_hold_data", 32'(out_data), 32'hFB);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("bp_ready0b", 32'(in_ready), 32'd0);
        chk("bp_hold_datab", 32'(out_data), 32'hFB);
        out_ready = 1'b1;
        #1;
        chk("bp_ready1", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_valid2", 32'(out_valid), 32'd1);
        chk("bp_data2",  32'(out_data), 32'hF0);
        @(negedge clk);
        chk("bp_valid_end", 32'(out_valid), 32'd0);

        // Aborted word: new in_first mid-word
        send_range(8'h0D, 0, 3);
        send_range(8'h02, 0, W - 1);
        in_valid = 1'b1;
        in_bit   = 1'b0;
        @(negedge clk);
        chk("ab_no_out", 32'(out_valid), 32'd0);
        chk("ab_ferr",   32'(frame_err), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("ab_valid", 32'(out_valid), 32'd1);
        chk("ab_data",  32'(out_data), 32'hFE);
        chk("ab_ferr_sticky", 32'(frame_err), 32'd1);
        @(negedge clk);

        // Reset mid-word with a held output
        out_ready = 1'b0;
        send_range(8'h55, 0, W);
        send_range(8'h33, 0, 4);
        #2 n_reset = 1'b0;
        #1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_data",  32'(out_data), 32'd0);
        chk("mr_neg",   32'(out_neg), 32'd0);
        chk("mr_ovf",   32'(out_ovf), 32'd0);
        chk("mr_ferr",  32'(frame_err), 32'd0);
        chk("mr_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 n_reset = 1'b1;
        out_ready = 1'b1;
        word_check(8'h7F, "w7F", 8'h81, 1'b1, 1'b0);
        chk("w7F_ferr", 32'(frame_err), 32'd0);
        @(negedge clk);

        // Bits in IDLE without in_first are dropped and flagged
        in_valid = 1'b1;
        in_first = 1'b0;
        in_bit   = 1'b1;
        @(posedge clk);
        #1 in_bit = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("idle_ferr",  32'(frame_err), 32'd1);
        chk("idle_valid", 32'(out_valid), 32'd0);

        // Random words with random gaps and back-pressure
        #2 n_reset = 1'b0;
        @(posedge clk);
        #1 n_reset = 1'b1;
        mon_en   = 1'b1;
        rand_rdy = 1'b1;
        for (int unsigned w = 0; w < NWORDS; w++) begin
            logic [W-1:0] r;
            r = W'($urandom);
            exp_q.push_back(r);
            for (int i = 0; i < int'(W); i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    for (int g = 0; g < int'($urandom_range(1, 2)); g++) begin
                        in_valid = 1'b0;
                        in_first = 1'($urandom_range(0, 1));
                        in_bit   = 1'($urandom_range(0, 1));
                        idle_cycle();
                    end
                end
                send_bit_hs(r[i], i == 0);
            end
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("rnd_words_rx", n_rx, NWORDS);
        chk("rnd_ferr", 32'(frame_err), 32'd0);
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
